// File: rtl/serial_bit_tx.sv
// -----------------------------------------------------------------------------
// serial_bit_tx
//   Bit-serial frame transmitter. One parallel word is accepted per
//   tx_valid/tx_ready handshake. It is sent as a frame on tx_out:
//   a start bit (0), DATA_WIDTH data bits LSB first, and a stop bit (1).
//   Each bit is held for CLKS_PER_BIT clocks.
//
//   Optional feature (macro SERIAL_BIT_TX_PARITY_EN):
//     An even-parity bit (the XOR of the word) is sent between the last
//     data bit and the stop bit. It also lasts CLKS_PER_BIT clocks.
//
// Parameters
//   DATA_WIDTH    word width in bits (>=1)
//   CLKS_PER_BIT  clocks per serial bit (>=1)
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   tx_data   word to send, sampled only at the handshake
//   tx_valid  upstream has a word
//   tx_ready  block can accept a word this cycle (state-decoded)
//   tx_out    registered serial line, idles high
//   busy      frame in progress
//   done      one-cycle pulse in the first idle cycle after a frame
// -----------------------------------------------------------------------------
module serial_bit_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

`ifdef SERIAL_BIT_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  // Even parity of a word: XOR of all its bits.
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        clk_cnt_r, clk_cnt_s;
  logic [IDX_W-1:0]        bit_idx_r, bit_idx_s;
  logic [DATA_WIDTH-1:0]   shift_r, shift_s, shifted_s;
  logic                    tx_out_r, tx_out_s;
  logic                    done_r, done_s;
  logic                    bit_end_s;
`ifdef SERIAL_BIT_TX_PARITY_EN
  // The shift register is consumed while sending, so parity is kept separately.
  logic                    parity_r, parity_s;
`endif

  assign bit_end_s = (clk_cnt_r == CNT_LAST);
  assign shifted_s = shift_r >> 1;

  assign tx_ready = (state_r == IDLE) && !reset;
  assign busy     = (state_r != IDLE);
  assign tx_out   = tx_out_r;
  assign done     = done_r;

  // Next-state, counters and next line value. tx_out is computed for the
  // next state so that the line changes in the same cycle as the state.
  always_comb begin
    state_s   = state_r;
    clk_cnt_s = clk_cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    tx_out_s  = 1'b1;
    done_s    = 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
    parity_s  = parity_r;
`endif
    case (state_r)
      IDLE: begin
        if (tx_valid) begin
          state_s   = START;
          clk_cnt_s = '0;
          bit_idx_s = '0;
          shift_s   = tx_data;
          tx_out_s  = 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
          parity_s  = even_parity(tx_data);
`endif
        end else begin
          tx_out_s = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s   = DATA;
          clk_cnt_s = '0;
          tx_out_s  = shift_r[0];
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_W'(1);
          tx_out_s  = 1'b0;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          clk_cnt_s = '0;
          if (bit_idx_r == IDX_LAST) begin
`ifdef SERIAL_BIT_TX_PARITY_EN
            state_s  = PARITY;
            tx_out_s = parity_r;
`else
            state_s  = STOP;
            tx_out_s = 1'b1;
`endif
          end else begin
            bit_idx_s = bit_idx_r + IDX_W'(1);
            shift_s   = shifted_s;
            tx_out_s  = shifted_s[0];
          end
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_W'(1);
          tx_out_s  = shift_r[0];
        end
      end
`ifdef SERIAL_BIT_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_s   = STOP;
          clk_cnt_s = '0;
          tx_out_s  = 1'b1;
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_W'(1);
          tx_out_s  = parity_r;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          state_s   = IDLE;
          clk_cnt_s = '0;
          done_s    = 1'b1;
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_W'(1);
        end
        tx_out_s = 1'b1;
      end
      default: begin
        // Unused encodings fall back to a clean idle line.
        state_s   = IDLE;
        clk_cnt_s = '0;
        bit_idx_s = '0;
        tx_out_s  = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      clk_cnt_r <= '0;
      bit_idx_r <= '0;
      shift_r   <= '0;
      tx_out_r  <= 1'b1;
      done_r    <= 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      clk_cnt_r <= clk_cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      tx_out_r  <= tx_out_s;
      done_r    <= done_s;
`ifdef SERIAL_BIT_TX_PARITY_EN
      parity_r  <= parity_s;
`endif
    end
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_tx
//   Self-checking bench for serial_bit_tx (DATA_WIDTH=8, CLKS_PER_BIT=4).
//   Inputs are driven and outputs are sampled on the falling clock edge.
//   Cycle k of a frame is the clock period that follows the handshake edge
//   by k-1 full periods. The reference model derives the expected line value
//   for cycle k directly from the frame layout.
// -----------------------------------------------------------------------------
module tb_serial_bit_tx;

  localparam int W = 8;
  localparam int C = 4;
`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int NBITS = W + 3;
`else
  localparam int NBITS = W + 2;
`endif
  localparam int FL = NBITS * C;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready, tx_out, busy, done;

  int errors = 0;
  int checks = 0;

  serial_bit_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_out   (tx_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Expected line value in cycle k (1-based) after the handshake of word.
  function automatic logic exp_line(input logic [W-1:0] word, input int k);
    int j;
    if (k < 1 || k > FL) return 1'b1;
    j = (k - 1) / C;
    if (j == 0) return 1'b0;
    if (j <= W) return word[j-1];
`ifdef SERIAL_BIT_TX_PARITY_EN
    if (j == W + 1) return ^word;
`endif
    return 1'b1;
  endfunction

  // Precondition: called at a falling edge with tx_valid=1 and tx_data=word
  // already driven. Checks every cycle through the done cycle.
  //   hold_valid: keep tx_valid high and present next_word for back-to-back.
  //   poke_cycle: if >0, drive tx_data=0 and pulse tx_valid in that cycle.
  task automatic check_frame(input logic [W-1:0] word, input string name,
                             input bit hold_valid, input logic [W-1:0] next_word,
                             input int poke_cycle);
    logic e_line, e_busy, e_done;
    for (int k = 1; k <= FL + 1; k++) begin
      @(negedge clk);
      e_line = exp_line(word, k);
      e_busy = (k <= FL);
      e_done = (k == FL + 1);
      checks++;
      if (tx_out !== e_line) begin
        errors++;
        $display("FAIL %s tx_out word=%h cycle=%0d got=%b exp=%b", name, word, k, tx_out, e_line);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL %s busy word=%h cycle=%0d got=%b exp=%b", name, word, k, busy, e_busy);
      end
      checks++;
      if (done !== e_done) begin
        errors++;
        $display("FAIL %s done word=%h cycle=%0d got=%b exp=%b", name, word, k, done, e_done);
      end
      checks++;
      if (tx_ready !== !e_busy) begin
        errors++;
        $display("FAIL %s tx_ready word=%h cycle=%0d got=%b exp=%b", name, word, k, tx_ready, !e_busy);
      end
      if (k == 1) begin
        if (hold_valid) tx_data = next_word;
        else tx_valid = 1'b0;
      end
      if (poke_cycle > 0 && k == poke_cycle) begin
        tx_data  = '0;
        tx_valid = 1'b1;
      end
      if (poke_cycle > 0 && k == poke_cycle + 1) tx_valid = 1'b0;
    end
    if (!hold_valid) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_after word=%h tx_out=%b busy=%b done=%b exp 1/0/0", name, word, tx_out, busy, done);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle=%0d tx_out=%b tx_ready=%b busy=%b done=%b exp 1/1/0/0",
                 k, tx_out, tx_ready, busy, done);
      end
    end
  endtask

  task automatic test_known_word();
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    check_frame(8'hA5, "known_a5", 1'b0, 8'h00, 0);
`ifdef SERIAL_BIT_TX_PARITY_EN
    tx_data = 8'h01;
    tx_valid = 1'b1;
    check_frame(8'h01, "parity_01", 1'b0, 8'h00, 0);
`endif
  endtask

  task automatic test_back_to_back();
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    check_frame(8'h3C, "b2b_first", 1'b1, 8'hFF, 0);
    check_frame(8'hFF, "b2b_second", 1'b0, 8'h00, 0);
  endtask

  task automatic test_ignore_busy();
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    check_frame(8'hA5, "ignore_busy", 1'b0, 8'h00, 12);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    w = 8'($urandom);
    tx_data = w;
    tx_valid = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      checks++;
      if (tx_out !== exp_line(w, k)) begin
        errors++;
        $display("FAIL reset_mid_pre cycle=%0d got=%b exp=%b", k, tx_out, exp_line(w, k));
      end
      if (k == 1) tx_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < FL + 4; k++) begin
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after cycle=%0d tx_out=%b busy=%b tx_ready=%b done=%b exp 1/0/1/0",
                 k, tx_out, busy, tx_ready, done);
      end
    end
    w = 8'($urandom);
    tx_data = w;
    tx_valid = 1'b1;
    check_frame(w, "reset_mid_resend", 1'b0, 8'h00, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] cur, nxt;
    bit b2b;
    cur = 8'($urandom);
    tx_data = cur;
    tx_valid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      nxt = 8'($urandom);
      b2b = (n < 5) && ($urandom_range(1, 0) == 1);
      check_frame(cur, "random", b2b, nxt, 0);
      if (!b2b) begin
        repeat ($urandom_range(3, 0)) @(negedge clk);
        tx_data = nxt;
        tx_valid = 1'b1;
      end
      cur = nxt;
    end
    // The loop leaves one word presented; let it run and check it too.
    check_frame(cur, "random_last", 1'b0, 8'h00, 0);
  endtask

  initial begin
    test_reset();
    test_known_word();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
